// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32I dispatch opcodes and the ALU reservation station entry layout.
package rv32i_types;
    localparam int PREG_BITS = 6;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    typedef struct packed {
        logic [PREG_BITS-1:0] ps1;
        logic [PREG_BITS-1:0] ps2;
        logic [PREG_BITS-1:0] pd;
        logic [PREG_BITS-1:0] rob_num;
        logic [6:0]           opcode;
        logic [2:0]           funct3;
        logic [6:0]           funct7;
        logic [31:0]          imm;
        logic [31:0]          pc;
    } rs_alu_entry_t;
endpackage

// File: rtl/prio_enc.sv
// prio_enc: lowest-index-first priority encoder.
module prio_enc #(
    parameter int N = 8,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);
    always_comb begin
        idx_o = '0;
        found_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = W'(i);
                found_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_reservation_station.sv
// alu_reservation_station: buffers renamed ALU ops until both sources are ready, snoops the CDB
// for wakeups and issues the lowest-index ready entry each cycle over a valid/ready handshake.
module alu_reservation_station
    import rv32i_types::*;
#(
    parameter int PHYS_REG_BITS = PREG_BITS,
    parameter int NUM_ENTRIES   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     disp_valid,
    input  logic [PHYS_REG_BITS-1:0] disp_ps1,
    input  logic [PHYS_REG_BITS-1:0] disp_ps2,
    input  logic                     disp_ps1_valid,
    input  logic                     disp_ps2_valid,
    input  logic [PHYS_REG_BITS-1:0] disp_pd,
    input  logic [PHYS_REG_BITS-1:0] disp_rob_num,
    input  logic [6:0]               disp_opcode,
    input  logic [2:0]               disp_funct3,
    input  logic [6:0]               disp_funct7,
    input  logic [31:0]              disp_imm,
    input  logic [31:0]              disp_pc,
    input  logic                     cdb_valid,
    input  logic [PHYS_REG_BITS-1:0] cdb_pd,
    output logic                     rs_full_add,
    output logic                     issue_valid,
    input  logic                     issue_ready,
    output logic [PHYS_REG_BITS-1:0] issue_ps1,
    output logic [PHYS_REG_BITS-1:0] issue_ps2,
    output logic [PHYS_REG_BITS-1:0] issue_pd,
    output logic [PHYS_REG_BITS-1:0] issue_rob_num,
    output logic [6:0]               issue_opcode,
    output logic [2:0]               issue_funct3,
    output logic [6:0]               issue_funct7,
    output logic [31:0]              issue_imm,
    output logic [31:0]              issue_pc
);
    localparam int IW = $clog2(NUM_ENTRIES);
    logic [NUM_ENTRIES-1:0] valid_q, valid_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d;
    rs_alu_entry_t          ent_q [NUM_ENTRIES];
    rs_alu_entry_t          sel_ent;
    logic [IW-1:0]          free_idx, sel_idx;
    logic                   free_found, alloc, wake, ins_rdy1, ins_rdy2;
    prio_enc #(.N(NUM_ENTRIES)) u_free (
        .req_i(~valid_q), .idx_o(free_idx), .found_o(free_found)
    );
    prio_enc #(.N(NUM_ENTRIES)) u_sel (
        .req_i(valid_q & rdy1_q & rdy2_q), .idx_o(sel_idx), .found_o(issue_valid)
    );
    assign rs_full_add = &valid_q;
    assign alloc       = disp_valid && free_found;
    assign wake        = cdb_valid && cdb_pd != '0;
    // Same-cycle CDB match lets a freshly dispatched entry skip the wakeup wait.
    assign ins_rdy1    = disp_ps1_valid || disp_ps1 == '0 || (cdb_valid && cdb_pd == disp_ps1);
    assign ins_rdy2    = disp_ps2_valid || disp_ps2 == '0 || (cdb_valid && cdb_pd == disp_ps2);
    always_comb begin
        valid_d = valid_q;
        rdy1_d = rdy1_q;
        rdy2_d = rdy2_q;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (wake && ent_q[i].ps1 == cdb_pd) rdy1_d[i] = 1'b1;
            if (wake && ent_q[i].ps2 == cdb_pd) rdy2_d[i] = 1'b1;
        end
        if (issue_valid && issue_ready) valid_d[sel_idx] = 1'b0;
        if (alloc) begin
            valid_d[free_idx] = 1'b1;
            rdy1_d[free_idx] = ins_rdy1;
            rdy2_d[free_idx] = ins_rdy2;
        end
        if (flush) valid_d = '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            rdy1_q <= '0;
            rdy2_q <= '0;
        end else begin
            valid_q <= valid_d;
            rdy1_q <= rdy1_d;
            rdy2_q <= rdy2_d;
        end
        if (alloc) ent_q[free_idx] <= '{ps1: disp_ps1, ps2: disp_ps2, pd: disp_pd,
            rob_num: disp_rob_num, opcode: disp_opcode, funct3: disp_funct3,
            funct7: disp_funct7, imm: disp_imm, pc: disp_pc};
    end
    assign sel_ent       = ent_q[sel_idx];
    assign issue_ps1     = issue_valid ? sel_ent.ps1 : '0;
    assign issue_ps2     = issue_valid ? sel_ent.ps2 : '0;
    assign issue_pd      = issue_valid ? sel_ent.pd : '0;
    assign issue_rob_num = issue_valid ? sel_ent.rob_num : '0;
    assign issue_opcode  = issue_valid ? sel_ent.opcode : '0;
    assign issue_funct3  = issue_valid ? sel_ent.funct3 : '0;
    assign issue_funct7  = issue_valid ? sel_ent.funct7 : '0;
    assign issue_imm     = issue_valid ? sel_ent.imm : '0;
    assign issue_pc      = issue_valid ? sel_ent.pc : '0;
endmodule

// File: tb/tb_alu_reservation_station.sv
// tb_alu_reservation_station: directed checks of allocation, wakeup, select order, full and flush.
module tb_alu_reservation_station;
    import rv32i_types::*;
    logic        clk = 0, rst, flush, disp_valid, disp_ps1_valid, disp_ps2_valid;
    logic [5:0]  disp_ps1, disp_ps2, disp_pd, disp_rob_num, cdb_pd;
    logic [6:0]  disp_opcode, disp_funct7;
    logic [2:0]  disp_funct3;
    logic [31:0] disp_imm, disp_pc;
    logic        cdb_valid, issue_ready, rs_full_add, issue_valid;
    logic [5:0]  issue_ps1, issue_ps2, issue_pd, issue_rob_num;
    logic [6:0]  issue_opcode, issue_funct7;
    logic [2:0]  issue_funct3;
    logic [31:0] issue_imm, issue_pc;
    int checks = 0, errors = 0;

    alu_reservation_station dut (
        .clk(clk), .rst(rst), .flush(flush), .disp_valid(disp_valid),
        .disp_ps1(disp_ps1), .disp_ps2(disp_ps2), .disp_ps1_valid(disp_ps1_valid),
        .disp_ps2_valid(disp_ps2_valid), .disp_pd(disp_pd), .disp_rob_num(disp_rob_num),
        .disp_opcode(disp_opcode), .disp_funct3(disp_funct3), .disp_funct7(disp_funct7),
        .disp_imm(disp_imm), .disp_pc(disp_pc), .cdb_valid(cdb_valid), .cdb_pd(cdb_pd),
        .rs_full_add(rs_full_add), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_ps1(issue_ps1), .issue_ps2(issue_ps2), .issue_pd(issue_pd),
        .issue_rob_num(issue_rob_num), .issue_opcode(issue_opcode), .issue_funct3(issue_funct3),
        .issue_funct7(issue_funct7), .issue_imm(issue_imm), .issue_pc(issue_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && !flush && disp_valid && rs_full_add) begin
            errors++;
            $error("FAIL disp_while_full: dispatch presented while rs_full_add=1");
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic disp(input logic [5:0] p1, input logic v1, input logic [5:0] p2,
                        input logic v2, input logic [5:0] pd, input logic [5:0] rob);
        disp_valid = 1; disp_ps1 = p1; disp_ps1_valid = v1; disp_ps2 = p2;
        disp_ps2_valid = v2; disp_pd = pd; disp_rob_num = rob; disp_opcode = OP_IMM;
        disp_funct3 = 3'd0; disp_funct7 = 7'd0; disp_imm = {26'd0, pd}; disp_pc = {24'd0, rob, 2'b00};
    endtask

    initial begin
        rst = 1; flush = 0; disp_valid = 0; disp_ps1 = 0; disp_ps2 = 0; disp_ps1_valid = 0;
        disp_ps2_valid = 0; disp_pd = 0; disp_rob_num = 0; disp_opcode = 0; disp_funct3 = 0;
        disp_funct7 = 0; disp_imm = 0; disp_pc = 0; cdb_valid = 0; cdb_pd = 0; issue_ready = 0;
        tick(); tick();
        rst = 0;
        tick();
        check("reset_full", rs_full_add, 0);
        check("reset_issue_valid", issue_valid, 0);
        check("reset_ps1", issue_ps1, 0);
        check("reset_pd", issue_pd, 0);
        check("reset_imm", issue_imm, 0);
        check("reset_pc", issue_pc, 0);
        check("reset_opcode", issue_opcode, 0);

        // ps1 ready at rename, ps2 is tag 0
        issue_ready = 1;
        disp(6'd5, 1, 6'd0, 0, 6'd10, 6'd1);
        tick();
        disp_valid = 0;
        check("t2_issue_valid", issue_valid, 1);
        check("t2_ps1", issue_ps1, 5);
        check("t2_pd", issue_pd, 10);
        check("t2_imm", issue_imm, 32'd10);
        check("t2_pc", issue_pc, 32'h4);
        check("t2_opcode", issue_opcode, 32'h13);
        tick();
        check("t2_freed", issue_valid, 0);

        // ps1=7 waits for a CDB wakeup
        disp(6'd7, 0, 6'd3, 1, 6'd11, 6'd2);
        tick();
        disp_valid = 0;
        check("t3_wait0", issue_valid, 0);
        tick();
        check("t3_wait1", issue_valid, 0);
        tick();
        check("t3_wait2", issue_valid, 0);
        cdb_valid = 1; cdb_pd = 6'd7;
        tick();
        cdb_valid = 0; cdb_pd = 0;
        check("t3_woken", issue_valid, 1);
        check("t3_ps1", issue_ps1, 7);
        check("t3_rob", issue_rob_num, 2);
        tick();
        check("t3_freed", issue_valid, 0);

        // same-cycle wakeup on insert
        disp(6'd4, 1, 6'd9, 0, 6'd12, 6'd3);
        cdb_valid = 1; cdb_pd = 6'd9;
        tick();
        disp_valid = 0; cdb_valid = 0; cdb_pd = 0;
        check("t4_issue_valid", issue_valid, 1);
        check("t4_ps2", issue_ps2, 9);
        check("t4_pd", issue_pd, 12);
        tick();
        check("t4_freed", issue_valid, 0);

        // fill all slots, none ready
        issue_ready = 0;
        for (int i = 0; i < 8; i++) begin
            disp(6'(20 + i), 0, 6'd0, 0, 6'(30 + i), 6'(i));
            tick();
            check("t5_fill_no_issue", issue_valid, 0);
        end
        disp_valid = 0;
        check("t5_full", rs_full_add, 1);
        cdb_valid = 1; cdb_pd = 6'd22;
        tick();
        check("t5_wake2_pd", issue_pd, 32);
        cdb_pd = 6'd20;
        tick();
        check("t5_preempt_pd", issue_pd, 30);
        cdb_pd = 6'd21;
        tick();
        cdb_valid = 0; cdb_pd = 0;
        check("t5_sel0_pd", issue_pd, 30);
        check("t5_full_before_issue", rs_full_add, 1);
        issue_ready = 1;
        tick();
        check("t5_full_after_issue", rs_full_add, 0);
        check("t5_sel1_pd", issue_pd, 31);
        tick();
        check("t5_sel2_pd", issue_pd, 32);
        tick();
        check("t5_drained", issue_valid, 0);
        check("t5_not_full", rs_full_add, 0);

        // clear leftovers, fill 4 ready slots, then flush with dispatch and issue
        flush = 1;
        tick();
        flush = 0;
        check("t6_flushed_valid", issue_valid, 0);
        issue_ready = 0;
        for (int i = 0; i < 4; i++) begin
            disp(6'(1 + i), 1, 6'd0, 0, 6'(40 + i), 6'(10 + i));
            tick();
        end
        check("t6_filled_pd", issue_pd, 40);
        disp(6'd8, 1, 6'd0, 0, 6'd50, 6'd20);
        flush = 1; issue_ready = 1;
        tick();
        flush = 0; disp_valid = 0; issue_ready = 0;
        check("t6_post_flush_valid", issue_valid, 0);
        check("t6_post_flush_full", rs_full_add, 0);
        disp(6'd9, 1, 6'd0, 0, 6'd51, 6'd21);
        tick();
        disp_valid = 0;
        check("t6_new_valid", issue_valid, 1);
        check("t6_new_pd", issue_pd, 51);
        check("t6_new_rob", issue_rob_num, 21);
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Integer-ALU reservation station, directly downstream of rename/dispatch. It accepts renamed ALU-class instructions (register-register and immediate ops) and buffers them until both source physical registers are ready.
- It snoops the common data bus (CDB) for wakeups and issues one ready instruction per cycle to the ALU functional unit using a valid/ready handshake.
- It drives rs_full_add back to dispatch.

Parameters:
- PHYS_REG_BITS, 6, width of physical register tags and ROB index.
- NUM_ENTRIES, 8, number of station slots; must be a power of two, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all entries (branch mispredict recovery)
- disp_valid  in  1  dispatch writes one instruction this cycle
- disp_ps1, disp_ps2  in  PHYS_REG_BITS  source physical tags
- disp_ps1_valid, disp_ps2_valid  in  1  source ready at rename
- disp_pd  in  PHYS_REG_BITS  destination physical tag
- disp_rob_num  in  PHYS_REG_BITS  ROB index
- disp_opcode  in  7  opcode
- disp_funct3  in  3  funct3
- disp_funct7  in  7  funct7
- disp_imm  in  32  pre-selected immediate (I or U)
- disp_pc  in  32  instruction PC
- cdb_valid  in  1  CDB broadcast valid
- cdb_pd  in  PHYS_REG_BITS  tag being broadcast
- rs_full_add  out  1  all slots occupied
- issue_valid  out  1  an entry is presented to the ALU
- issue_ready  in  1  ALU accepts this cycle
- issue_ps1, issue_ps2, issue_pd, issue_rob_num  out  PHYS_REG_BITS  payload
- issue_opcode  out  7  payload
- issue_funct3  out  3  payload
- issue_funct7  out  7  payload
- issue_imm, issue_pc  out  32  payload

Behaviour:
- Storage: per slot, a valid bit, rdy1, rdy2, and the payload. All state is registered.
- Reset or flush (synchronous): all valid bits are cleared in the next cycle. Payload contents are don't-care. Flush takes priority over a same-cycle dispatch and a same-cycle issue; neither takes effect.
- Output values after reset: rs_full_add=0 and issue_valid=0. issue_* payload outputs are 0 whenever issue_valid=0.
- Allocation:
  - When disp_valid=1 and not full, the lowest-index free slot is written at the clock edge.
  - disp_valid=1 while full is dropped silently; a bench assertion flags it as an error.
- Readiness on insert: rdyN = disp_psN_valid OR disp_psN==0 OR (cdb_valid AND cdb_pd==disp_psN). This captures a same-cycle wakeup.
- Wakeup: each cycle, every valid slot with rdyN=0 and matching cdb_pd sets rdyN=1 when cdb_valid=1. Tag 0 is never broadcast as a wakeup.
- Select (combinational from registered state):
  - Eligible = valid AND rdy1 AND rdy2.
  - The lowest-index eligible slot drives issue_*, and issue_valid=1.
  - An entry woken this cycle becomes eligible next cycle, giving a minimum dispatch-to-issue latency of 1 cycle.
- Issue handshake:
  - When issue_valid AND issue_ready, the selected slot's valid bit clears at the edge.
  - When issue_ready=0, the selection is recomputed next cycle. A lower-index entry that becomes eligible may pre-empt the current one; the payload is not required to be held stable.
- rs_full_add = AND of all valid bits, combinational from registered state. It does not count a same-cycle issue, so full followed by issue frees a slot one cycle later. The same-cycle freed slot is not reusable by a dispatch in that cycle.
- Simultaneous dispatch and issue: allowed when not full. The slot issued this cycle is not reallocated in the same cycle.
- Occupancy invariant: the number of valid slots is at most NUM_ENTRIES and never underflows.

Decomposition:
- Shared package rv32i_types holds:
  - rs_alu_entry_t, a packed struct of {ps1, ps2, pd, rob_num, opcode, funct3, funct7, imm, pc}
  - the opcode constants already used by dispatch
- Sub-module prio_enc (parameterised width N, input vector, outputs index and found). It is instantiated twice: once for free-slot allocation and once for the ready select.

Test Plan:
1. Reset then idle -> rs_full_add=0, issue_valid=0, and all issue_* outputs are 0.
2. Dispatch one entry with ps1=5, ps1_valid=1, ps2=0 (tag 0, counts as ready), issue_ready=1 -> issue_valid=1 on the next cycle with ps1=5. The slot frees after the handshake.
3. Dispatch with ps1=7 not ready. Hold 3 cycles, then cdb_valid=1 with cdb_pd=7 -> issue_valid rises exactly 1 cycle after the broadcast.
4. Dispatch ps2=9 in the same cycle that the CDB broadcasts 9 -> the entry issues on the next cycle with no further wakeup.
5. Fill all 8 slots with non-ready sources -> rs_full_add=1. Wake 3 slots, with issue_ready=1 -> issue proceeds in index order 0, then 1, then 2. rs_full_add falls the cycle after the first issue.
6. Fill 4 slots, then assert flush together with disp_valid and issue_ready -> no issue occurs. Next cycle issue_valid=0, rs_full_add=0, and a new dispatch lands in slot 0.
